// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and constants for the two-port SRAM arbiter
package sram_arb_pkg;

    localparam int AW_DEF     = 4;
    localparam int DW_DEF     = 4;
    localparam int SRAM_DEPTH = 16;
    localparam int ID_W       = 1;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - requester-side command/response bundle for both clients
interface sram_arbiter_if #(
    parameter int AW = sram_arb_pkg::AW_DEF,
    parameter int DW = sram_arb_pkg::DW_DEF
);

    logic          req0;
    logic          wr0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          gnt0;
    logic          rvalid0;
    logic [DW-1:0] rdata0;

    logic          req1;
    logic          wr1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          gnt1;
    logic          rvalid1;
    logic [DW-1:0] rdata1;

    modport slave (
        input  req0, wr0, addr0, wdata0,
        input  req1, wr1, addr1, wdata1,
        output gnt0, rvalid0, rdata0,
        output gnt1, rvalid1, rdata1
    );

    modport master (
        output req0, wr0, addr0, wdata0,
        output req1, wr1, addr1, wdata1,
        input  gnt0, rvalid0, rdata0,
        input  gnt1, rvalid1, rdata1
    );

endinterface

// File: rtl/sram_arbiter_rr_arb2.sv
// rtl/sram_arbiter_rr_arb2.sv - two-way round-robin grant logic (purely combinational)
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // last names the requester granted most recently; a tie goes to the other one
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - post-reset clear, round-robin command issue and read return for SRAM4x16
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int READ_LAT = 1,
    parameter int DW       = DW_DEF,
    parameter int AW       = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    sram_arbiter_if.slave bus,
    output logic          busy_init,
    output logic          sram_rst,
    output logic          sram_wr,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_data,
    input  logic [DW-1:0] sram_out
);

    localparam int         DEPTH  = 1 + READ_LAT;
    localparam logic [0:0] S_INIT = ST_INIT;
    localparam logic [0:0] S_RUN  = ST_RUN;

    logic [0:0]      state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            busy_init_q, busy_init_d;
    logic            sram_rst_q, sram_rst_d;
    logic            sram_wr_q, sram_wr_d;
    logic [AW-1:0]   sram_addr_q, sram_addr_d;
    logic [DW-1:0]   sram_data_q, sram_data_d;
    logic [ID_W-1:0] last_q, last_d;
    logic [DEPTH-1:0] pipe_rd_q, pipe_rd_d;
    logic [DEPTH-1:0] pipe_id_q, pipe_id_d;
    logic            rvalid0_q, rvalid0_d;
    logic            rvalid1_q, rvalid1_d;
    logic [DW-1:0]   rdata0_q, rdata0_d;
    logic [DW-1:0]   rdata1_q, rdata1_d;

    logic [1:0] arb_req;
    logic [1:0] arb_gnt;

    assign arb_req = (state_q == S_RUN) ? {bus.req1, bus.req0} : 2'b00;

    rr_arb2 u_rr_arb2 (
        .req  (arb_req),
        .last (last_q),
        .gnt  (arb_gnt)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy_init_d = busy_init_q;
        sram_rst_d  = 1'b0;
        sram_wr_d   = 1'b0;
        sram_addr_d = sram_addr_q;
        sram_data_d = sram_data_q;
        last_d      = last_q;
        pipe_rd_d   = pipe_rd_q << 1;
        pipe_id_d   = pipe_id_q << 1;

        if (state_q == S_INIT) begin
            sram_wr_d   = 1'b1;
            sram_addr_d = cnt_q;
            sram_data_d = '0;
            cnt_d       = cnt_q + 1'b1;
            if (cnt_q == AW'(SRAM_DEPTH - 1)) begin
                state_d     = S_RUN;
                busy_init_d = 1'b0;
            end
        end else if (|arb_gnt) begin
            last_d       = arb_gnt[1];
            sram_wr_d    = arb_gnt[1] ? bus.wr1    : bus.wr0;
            sram_addr_d  = arb_gnt[1] ? bus.addr1  : bus.addr0;
            sram_data_d  = arb_gnt[1] ? bus.wdata1 : bus.wdata0;
            pipe_rd_d[0] = ~sram_wr_d;
            pipe_id_d[0] = arb_gnt[1];
        end

        // the oldest pipeline slot lines up with sram_out for the read it tracks
        rvalid0_d = pipe_rd_q[DEPTH-1] & ~pipe_id_q[DEPTH-1];
        rvalid1_d = pipe_rd_q[DEPTH-1] &  pipe_id_q[DEPTH-1];
        rdata0_d  = rvalid0_d ? sram_out : rdata0_q;
        rdata1_d  = rvalid1_d ? sram_out : rdata1_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_INIT;
            cnt_q       <= '0;
            busy_init_q <= 1'b1;
            sram_rst_q  <= 1'b1;
            sram_wr_q   <= 1'b0;
            sram_addr_q <= '0;
            sram_data_q <= '0;
            last_q      <= 1'b1;
            pipe_rd_q   <= '0;
            pipe_id_q   <= '0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_init_q <= busy_init_d;
            sram_rst_q  <= sram_rst_d;
            sram_wr_q   <= sram_wr_d;
            sram_addr_q <= sram_addr_d;
            sram_data_q <= sram_data_d;
            last_q      <= last_d;
            pipe_rd_q   <= pipe_rd_d;
            pipe_id_q   <= pipe_id_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    assign bus.gnt0    = arb_gnt[0];
    assign bus.gnt1    = arb_gnt[1];
    assign bus.rvalid0 = rvalid0_q;
    assign bus.rvalid1 = rvalid1_q;
    assign bus.rdata0  = rdata0_q;
    assign bus.rdata1  = rdata1_q;

    assign busy_init = busy_init_q;
    assign sram_rst  = sram_rst_q;
    assign sram_wr   = sram_wr_q;
    assign sram_addr = sram_addr_q;
    assign sram_data = sram_data_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench with SRAM4x16 model and transaction-level reference
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    localparam int AW = 4;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          busy_init;
    logic          sram_rst;
    logic          sram_wr;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_data;
    logic [DW-1:0] sram_out;

    always #5 clk = ~clk;

    sram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    sram_arbiter #(.READ_LAT(1), .DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy_init (busy_init),
        .sram_rst  (sram_rst),
        .sram_wr   (sram_wr),
        .sram_addr (sram_addr),
        .sram_data (sram_data),
        .sram_out  (sram_out)
    );

    // SRAM4x16: registered read, one cycle latency; contents scrambled while in reset
    logic [DW-1:0] mem [SRAM_DEPTH];
    always @(posedge clk) begin
        if (sram_rst) begin
            for (int i = 0; i < SRAM_DEPTH; i++) mem[i] <= 4'hE;
        end else if (sram_wr) begin
            mem[sram_addr] <= sram_data;
        end
        sram_out <= mem[sram_addr];
    end

    typedef struct {
        int            due;
        int            who;
        logic [DW-1:0] data;
    } resp_t;

    typedef struct {
        logic r0, w0; logic [3:0] a0, d0;
        logic r1, w1; logic [3:0] a1, d1;
        logic eg0, eg1, ev0, ev1; logic [3:0] erd0, erd1;
    } vec_t;

    int            checks;
    int            failures;
    int            cyc;
    int            mdl_last;
    logic [DW-1:0] mdl_mem [SRAM_DEPTH];
    logic [DW-1:0] exp_rd0, exp_rd1;
    resp_t         exp_q [$];
    vec_t          tbl [15];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < SRAM_DEPTH; i++) mdl_mem[i] = '0;
        mdl_last = 1;
        exp_rd0  = '0;
        exp_rd1  = '0;
        exp_q.delete();
    endtask

    task automatic drive(input logic r0, w0, input logic [3:0] a0, d0,
                         input logic r1, w1, input logic [3:0] a1, d1);
        bus.req0 = r0; bus.wr0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
        bus.req1 = r1; bus.wr1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
    endtask

    // one RUN-state cycle: drive, compare against the reference, then advance the reference
    task automatic step(input logic r0, w0, input logic [3:0] a0, d0,
                        input logic r1, w1, input logic [3:0] a1, d1,
                        output logic g0, g1, v0, v1, output logic [3:0] rd0, rd1);
        int         mg;
        logic       ev0, ev1, wr;
        logic [3:0] a, d;
        resp_t      r;
        @(negedge clk);
        drive(r0, w0, a0, d0, r1, w1, a1, d1);
        #1;
        mg = -1;
        if (r0 && r1) mg = (mdl_last == 1) ? 0 : 1;
        else if (r0)  mg = 0;
        else if (r1)  mg = 1;
        ev0 = 1'b0;
        ev1 = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            r = exp_q.pop_front();
            if (r.who == 0) begin ev0 = 1'b1; exp_rd0 = r.data; end
            else            begin ev1 = 1'b1; exp_rd1 = r.data; end
        end
        chk("gnt0",    8'(bus.gnt0),    8'(mg == 0));
        chk("gnt1",    8'(bus.gnt1),    8'(mg == 1));
        chk("rvalid0", 8'(bus.rvalid0), 8'(ev0));
        chk("rvalid1", 8'(bus.rvalid1), 8'(ev1));
        chk("rdata0",  8'(bus.rdata0),  8'(exp_rd0));
        chk("rdata1",  8'(bus.rdata1),  8'(exp_rd1));
        if (mg >= 0) begin
            mdl_last = mg;
            wr = (mg == 0) ? w0 : w1;
            a  = (mg == 0) ? a0 : a1;
            d  = (mg == 0) ? d0 : d1;
            if (wr) mdl_mem[a] = d;
            else begin
                r.due = cyc + 3; r.who = mg; r.data = mdl_mem[a];
                exp_q.push_back(r);
            end
        end
        g0 = bus.gnt0; g1 = bus.gnt1; v0 = bus.rvalid0; v1 = bus.rvalid1;
        rd0 = bus.rdata0; rd1 = bus.rdata1;
        cyc++;
    endtask

    task automatic idle_step();
        logic g0, g1, v0, v1;
        logic [3:0] rd0, rd1;
        step(0, 0, 0, 0, 0, 0, 0, 0, g0, g1, v0, v1, rd0, rd1);
    endtask

    // reset pulse with both requesters asking, then the 16-cycle clear sequence
    task automatic reset_and_init();
        @(negedge clk);
        rst = 1'b0;
        drive(1, 0, 4'h9, 0, 1, 0, 4'h2, 0);
        @(negedge clk);
        #1;
        chk("rst_sram_rst", 8'(sram_rst),    8'd1);
        chk("rst_busy",     8'(busy_init),   8'd1);
        chk("rst_sram_wr",  8'(sram_wr),     8'd0);
        chk("rst_addr",     8'(sram_addr),   8'd0);
        chk("rst_data",     8'(sram_data),   8'd0);
        chk("rst_rvalid0",  8'(bus.rvalid0), 8'd0);
        chk("rst_rvalid1",  8'(bus.rvalid1), 8'd0);
        chk("rst_rdata0",   8'(bus.rdata0),  8'd0);
        chk("rst_rdata1",   8'(bus.rdata1),  8'd0);
        chk("rst_gnt0",     8'(bus.gnt0),    8'd0);
        rst = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 16) drive(0, 0, 0, 0, 0, 0, 0, 0);
            #1;
            chk("init_sram_rst", 8'(sram_rst),    8'd0);
            chk("init_wr",       8'(sram_wr),     8'd1);
            chk("init_addr",     8'(sram_addr),   8'(k - 1));
            chk("init_data",     8'(sram_data),   8'd0);
            chk("init_busy",     8'(busy_init),   8'(k < 16));
            chk("init_gnt0",     8'(bus.gnt0),    8'd0);
            chk("init_gnt1",     8'(bus.gnt1),    8'd0);
            chk("init_rvalid0",  8'(bus.rvalid0), 8'd0);
            chk("init_rvalid1",  8'(bus.rvalid1), 8'd0);
        end
        model_reset();
    endtask

    initial begin
        logic       g0, g1, v0, v1, p0, p1, pw0, pw1;
        logic [3:0] rd0, rd1, pa0, pa1, pd0, pd1;

        checks   = 0;
        failures = 0;
        cyc      = 0;
        rst      = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();

        //          r0 w0 a0    d0    r1 w1 a1    d1    g0 g1 v0 v1 rd0   rd1
        tbl[0]  = '{1, 0, 4'h5, 4'h0, 0, 0, 4'h0, 4'h0, 1, 0, 0, 0, 4'h0, 4'h0};
        tbl[1]  = '{1, 1, 4'h7, 4'h5, 0, 0, 4'h0, 4'h0, 1, 0, 0, 0, 4'h0, 4'h0};
        tbl[2]  = '{0, 0, 4'h0, 4'h0, 1, 1, 4'h3, 4'hA, 0, 1, 0, 0, 4'h0, 4'h0};
        tbl[3]  = '{0, 0, 4'h0, 4'h0, 1, 0, 4'h3, 4'h0, 0, 1, 1, 0, 4'h0, 4'h0};
        tbl[4]  = '{0, 0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0};
        tbl[5]  = '{1, 0, 4'h7, 4'h0, 1, 0, 4'h3, 4'h0, 1, 0, 0, 0, 4'h0, 4'h0};
        tbl[6]  = '{1, 0, 4'h7, 4'h0, 1, 0, 4'h3, 4'h0, 0, 1, 0, 1, 4'h0, 4'hA};
        tbl[7]  = '{1, 0, 4'h7, 4'h0, 1, 0, 4'h3, 4'h0, 1, 0, 0, 0, 4'h0, 4'hA};
        tbl[8]  = '{1, 0, 4'h7, 4'h0, 1, 0, 4'h3, 4'h0, 0, 1, 1, 0, 4'h5, 4'hA};
        tbl[9]  = '{1, 0, 4'h7, 4'h0, 1, 0, 4'h3, 4'h0, 1, 0, 0, 1, 4'h5, 4'hA};
        tbl[10] = '{1, 0, 4'h7, 4'h0, 1, 0, 4'h3, 4'h0, 0, 1, 1, 0, 4'h5, 4'hA};
        tbl[11] = '{0, 0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0, 0, 1, 4'h5, 4'hA};
        tbl[12] = '{0, 0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0, 1, 0, 4'h5, 4'hA};
        tbl[13] = '{0, 0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0, 0, 1, 4'h5, 4'hA};
        tbl[14] = '{0, 0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0, 0, 0, 4'h5, 4'hA};

        reset_and_init();

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
                 tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1,
                 g0, g1, v0, v1, rd0, rd1);
            chk($sformatf("tbl%0d_gnt0", i),    8'(g0),  8'(tbl[i].eg0));
            chk($sformatf("tbl%0d_gnt1", i),    8'(g1),  8'(tbl[i].eg1));
            chk($sformatf("tbl%0d_rvalid0", i), 8'(v0),  8'(tbl[i].ev0));
            chk($sformatf("tbl%0d_rvalid1", i), 8'(v1),  8'(tbl[i].ev1));
            chk($sformatf("tbl%0d_rdata0", i),  8'(rd0), 8'(tbl[i].erd0));
            chk($sformatf("tbl%0d_rdata1", i),  8'(rd1), 8'(tbl[i].erd1));
        end

        for (int i = 0; i < 16; i++)
            step(1, 1, 4'($urandom), 4'($urandom), 0, 0, 0, 0, g0, g1, v0, v1, rd0, rd1);
        for (int i = 0; i < 16; i++)
            step(1, 0, 4'(i), 0, 0, 0, 0, 0, g0, g1, v0, v1, rd0, rd1);
        for (int i = 0; i < 4; i++) idle_step();

        p0 = 1'b0; p1 = 1'b0;
        pw0 = 1'b0; pw1 = 1'b0; pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
        for (int n = 0; n < 400; n++) begin
            if (!p0 && $urandom_range(0, 3) != 0) begin
                p0 = 1'b1; pw0 = 1'($urandom); pa0 = 4'($urandom); pd0 = 4'($urandom);
            end
            if (!p1 && $urandom_range(0, 3) != 0) begin
                p1 = 1'b1; pw1 = 1'($urandom); pa1 = 4'($urandom); pd1 = 4'($urandom);
            end
            step(p0, pw0, pa0, pd0, p1, pw1, pa1, pd1, g0, g1, v0, v1, rd0, rd1);
            if (g0) p0 = 1'b0;
            if (g1) p1 = 1'b0;
        end
        for (int i = 0; i < 4; i++) idle_step();

        step(1, 1, 4'h9, 4'hC, 0, 0, 0, 0, g0, g1, v0, v1, rd0, rd1);
        step(1, 0, 4'h9, 4'h0, 0, 0, 0, 0, g0, g1, v0, v1, rd0, rd1);
        reset_and_init();
        step(1, 0, 4'h9, 4'h0, 0, 0, 0, 0, g0, g1, v0, v1, rd0, rd1);
        for (int i = 0; i < 4; i++) idle_step();
        chk("post_reset_rdata0", 8'(bus.rdata0), 8'd0);
        chk("resp_drained", 8'(exp_q.size()), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
